// File: rtl/wrr_arb_pkg.sv
// Shared types and constants for the weighted round-robin packet arbiter.
package wrr_arb_pkg;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    OFFER  = 2'd1,
    RELOAD = 2'd2
  } arb_state_e;

  localparam int WEIGHT_W_DEF = 4;
  typedef logic [WEIGHT_W_DEF-1:0] weight_t;

  localparam int STAT_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority selector: first set bit of mask at or after ptr, wrapping.
module rr_pick #(
  parameter int  N   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] id,
  output logic           any
);

  logic [IDW-1:0] idx;

  always_comb begin
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      // modulo keeps the wrap correct for non-power-of-two N
      idx = IDW'((int'(ptr) + k) % N);
      if (!any && mask[idx]) begin
        any         = 1'b1;
        onehot[idx] = 1'b1;
        id          = idx;
      end
    end
  end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter, one grant per packet, one credit per accept.
// Optional per-input accepted-grant counters under macro WRR_GNT_CNT_EN.
//
// state  | meaning
// SELECT | look for an eligible requester; start an offer or request a reload
// OFFER  | grant held stable until the consumer accepts it
// RELOAD | one bubble cycle copying every weight into its credit
module wrr_pkt_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int  WIDTH_REQ      = 8,
  parameter int  WEIGHT_WIDTH   = WEIGHT_W_DEF,
  parameter int  DEFAULT_WEIGHT = 1,
  localparam int ID_WIDTH       = $clog2(WIDTH_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH_REQ-1:0]    req_i,
  output logic [WIDTH_REQ-1:0]    req_ack_o,
  output logic [WIDTH_REQ-1:0]    gnt_o,
  output logic [ID_WIDTH-1:0]     gnt_id_o,
  output logic                    gnt_vld_o,
  input  logic                    gnt_rdy_i,
  input  logic                    cfg_we_i,
  input  logic [ID_WIDTH-1:0]     cfg_addr_i,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight_i
`ifdef WRR_GNT_CNT_EN
  ,
  input  logic                                  stat_clr_i,
  output logic [WIDTH_REQ-1:0][STAT_CNT_W-1:0]  stat_cnt_o
`endif
);

  arb_state_e state, state_nxt;

  logic [WEIGHT_WIDTH-1:0] weight [WIDTH_REQ];
  logic [WEIGHT_WIDTH-1:0] credit [WIDTH_REQ];
  logic [ID_WIDTH-1:0]     ptr;

  logic [WIDTH_REQ-1:0] weighted_req, eligible, pick_oh;
  logic [ID_WIDTH-1:0]  pick_id;
  logic                 pick_any, accept;

  always_comb begin
    weighted_req = '0;
    eligible     = '0;
    for (int i = 0; i < WIDTH_REQ; i++) begin
      weighted_req[i] = req_i[i] && (weight[i] != '0);
      eligible[i]     = weighted_req[i] && (credit[i] != '0);
    end
  end

  rr_pick #(.N(WIDTH_REQ)) u_pick (
    .mask   (eligible),
    .ptr    (ptr),
    .onehot (pick_oh),
    .id     (pick_id),
    .any    (pick_any)
  );

  // a reset in the accept cycle kills the handshake, so no ack escapes
  assign accept    = gnt_vld_o & gnt_rdy_i & ~reset;
  assign req_ack_o = accept ? gnt_o : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      SELECT: begin
        if (pick_any)           state_nxt = OFFER;
        else if (|weighted_req) state_nxt = RELOAD;
      end
      OFFER:   if (accept) state_nxt = SELECT;
      RELOAD:  state_nxt = SELECT;
      default: state_nxt = SELECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SELECT;
      ptr       <= '0;
      gnt_o     <= '0;
      gnt_id_o  <= '0;
      gnt_vld_o <= 1'b0;
      for (int i = 0; i < WIDTH_REQ; i++) credit[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
    end else begin
      state <= state_nxt;
      case (state)
        SELECT: begin
          if (pick_any) begin
            gnt_o     <= pick_oh;
            gnt_id_o  <= pick_id;
            gnt_vld_o <= 1'b1;
          end
        end
        RELOAD: begin
          for (int i = 0; i < WIDTH_REQ; i++) credit[i] <= weight[i];
        end
        OFFER: begin
          if (accept) begin
            if (credit[gnt_id_o] != '0)
              credit[gnt_id_o] <= credit[gnt_id_o] - WEIGHT_WIDTH'(1);
            ptr       <= (int'(gnt_id_o) == WIDTH_REQ - 1) ? '0 : gnt_id_o + ID_WIDTH'(1);
            gnt_o     <= '0;
            gnt_vld_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // weights are separate from credits so a write never disturbs the current round
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH_REQ; i++) weight[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
    end else if (cfg_we_i && (int'(cfg_addr_i) < WIDTH_REQ)) begin
      weight[cfg_addr_i] <= cfg_weight_i;
    end
  end

`ifdef WRR_GNT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || stat_clr_i) begin
      stat_cnt_o <= '0;
    end else if (accept && (stat_cnt_o[gnt_id_o] != '1)) begin
      stat_cnt_o[gnt_id_o] <= stat_cnt_o[gnt_id_o] + STAT_CNT_W'(1);
    end
  end
`else
  // no grant statistics in this build
`endif

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Directed and randomized bench for wrr_pkt_arbiter against a per-cycle reference model.
module tb_wrr_pkt_arbiter;
  import wrr_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req_i, req_ack_o, gnt_o;
  logic [2:0] gnt_id_o, cfg_addr_i;
  logic       gnt_vld_o, gnt_rdy_i, cfg_we_i;
  logic [3:0] cfg_weight_i;
`ifdef WRR_GNT_CNT_EN
  logic             stat_clr_i;
  logic [7:0][15:0] stat_cnt_o;
`endif

  wrr_pkt_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .req_ack_o    (req_ack_o),
    .gnt_o        (gnt_o),
    .gnt_id_o     (gnt_id_o),
    .gnt_vld_o    (gnt_vld_o),
    .gnt_rdy_i    (gnt_rdy_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_weight_i (cfg_weight_i)
`ifdef WRR_GNT_CNT_EN
    ,
    .stat_clr_i   (stat_clr_i),
    .stat_cnt_o   (stat_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: weights, credits, pointer, outstanding offer, pending bubble
  int m_w [8];
  int m_c [8];
  int m_stat [8];
  int m_ptr, m_id;
  bit m_vld, m_bubble;
  int acc_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 8; i++) begin
      m_w[i] = 1; m_c[i] = 1; m_stat[i] = 0;
    end
    m_ptr = 0; m_id = 0; m_vld = 0; m_bubble = 0;
  endtask

  task automatic step(input logic [7:0] req, input logic rdy, input logic rst,
                      input logic we, input int addr, input int wv, input logic clr);
    logic [7:0] exp_oh;
    int pick;
    bit any_w;
    @(negedge clk);
    reset = rst; req_i = req; gnt_rdy_i = rdy;
    cfg_we_i = we; cfg_addr_i = 3'(addr); cfg_weight_i = 4'(wv);
`ifdef WRR_GNT_CNT_EN
    stat_clr_i = clr;
`endif
    #1;
    exp_oh = m_vld ? 8'(1 << m_id) : 8'h00;
    check("gnt_vld", 32'(gnt_vld_o), 32'(m_vld));
    check("gnt_o", 32'(gnt_o), 32'(exp_oh));
    if (m_vld) check("gnt_id", 32'(gnt_id_o), 32'(m_id));
    check("req_ack", 32'(req_ack_o), (m_vld && rdy && !rst) ? 32'(exp_oh) : 32'h0);
`ifdef WRR_GNT_CNT_EN
    for (int i = 0; i < 8; i++) check("stat_cnt", 32'(stat_cnt_o[i]), 32'(m_stat[i]));
`endif
    if (rst) begin
      mreset();
    end else begin
`ifdef WRR_GNT_CNT_EN
      if (clr) for (int i = 0; i < 8; i++) m_stat[i] = 0;
      else if (m_vld && rdy && m_stat[m_id] < 65535) m_stat[m_id]++;
`else
      if (clr) pick = 0;
`endif
      if (m_vld) begin
        if (rdy) begin
          m_c[m_id]--;
          m_ptr = (m_id + 1) % 8;
          m_vld = 0;
          acc_q.push_back(m_id);
        end
      end else if (m_bubble) begin
        m_c = m_w;
        m_bubble = 0;
      end else begin
        pick = -1; any_w = 0;
        for (int k = 0; k < 8; k++) begin
          int i;
          i = (m_ptr + k) % 8;
          if (req[i] && m_w[i] != 0) any_w = 1;
          if (pick < 0 && req[i] && m_w[i] != 0 && m_c[i] != 0) pick = i;
        end
        if (pick >= 0) begin m_vld = 1; m_id = pick; end
        else if (any_w) m_bubble = 1;
      end
      if (we) m_w[addr] = wv;
    end
  endtask

  int zeros, ones, found;
  int exp_t1 [4] = '{0, 2, 0, 2};
  int exp_t2 [4] = '{0, 1, 0, 0};

  initial begin
    reset = 1'b1; req_i = '0; gnt_rdy_i = 1'b0;
    cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_weight_i = '0;
`ifdef WRR_GNT_CNT_EN
    stat_clr_i = 1'b0;
`endif
    mreset();
    repeat (2) @(posedge clk);

    // reset state
    step(8'h00, 0, 1, 0, 0, 0, 0);
    check("rst_gnt_id", 32'(gnt_id_o), 32'h0);

    // plain round robin on inputs 0 and 2
    acc_q.delete();
    repeat (12) step(8'h05, 1, 0, 0, 0, 0, 0);
    check("t1_grant_count", acc_q.size(), 4);
    for (int j = 0; j < 4 && j < acc_q.size(); j++) check("t1_grant_order", acc_q[j], exp_t1[j]);

    // weights 3:1
    step(8'h00, 0, 1, 0, 0, 0, 0);
    step(8'h00, 1, 0, 1, 0, 3, 0);
    step(8'h00, 1, 0, 1, 1, 1, 0);
    acc_q.delete();
    for (int n = 0; n < 300 && acc_q.size() < 42; n++) step(8'h03, 1, 0, 0, 0, 0, 0);
    check("t2_enough_grants", 32'(acc_q.size() >= 42), 32'h1);
    zeros = 0; ones = 0;
    for (int j = 2; j < 42 && j < acc_q.size(); j++) begin
      if (acc_q[j] == 0) zeros++;
      if (acc_q[j] == 1) ones++;
    end
    check("t2_w0_share", zeros, 30);
    check("t2_w1_share", ones, 10);
    for (int j = 0; j < 4 && j + 2 < acc_q.size(); j++) check("t2_pattern", acc_q[j+2], exp_t2[j]);

    // offer held while consumer stalls and request drops
    step(8'h00, 0, 1, 0, 0, 0, 0);
    step(8'h04, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      step(8'h00, 0, 0, 0, 0, 0, 0);
      check("t3_gnt_hold", 32'(gnt_o), 32'h04);
      check("t3_id_hold", 32'(gnt_id_o), 32'h2);
      check("t3_no_ack", 32'(req_ack_o), 32'h0);
    end
    step(8'h00, 1, 0, 0, 0, 0, 0);
    check("t3_ack", 32'(req_ack_o), 32'h04);
    step(8'h00, 0, 0, 0, 0, 0, 0);

    // masked input, then re-enabled
    step(8'h00, 0, 1, 0, 0, 0, 0);
    step(8'h00, 0, 0, 1, 1, 0, 0);
    acc_q.delete();
    repeat (10) step(8'h02, 1, 0, 0, 0, 0, 0);
    check("t4_masked_no_grant", acc_q.size(), 0);
    step(8'h02, 1, 0, 1, 1, 2, 0);
    found = 0;
    for (int n = 0; n < 4 && found == 0; n++) begin
      step(8'h02, 1, 0, 0, 0, 0, 0);
      found = (gnt_vld_o === 1'b1 && gnt_id_o === 3'd1) ? 1 : 0;
    end
    check("t4_grant_after_rewrite", found, 1);

    // reset during an offer
    step(8'h00, 0, 1, 0, 0, 0, 0);
    step(8'h01, 0, 0, 0, 0, 0, 0);
    step(8'h01, 0, 0, 0, 0, 0, 0);
    check("t5_offer_up", 32'(gnt_vld_o), 32'h1);
    step(8'h01, 1, 1, 0, 0, 0, 0);
    check("t5_ack_in_reset", 32'(req_ack_o), 32'h0);
    step(8'h81, 1, 0, 0, 0, 0, 0);
    check("t5_vld_dropped", 32'(gnt_vld_o), 32'h0);
    step(8'h81, 1, 0, 0, 0, 0, 0);
    check("t5_first_after_reset", 32'(gnt_id_o), 32'h0);

`ifdef WRR_GNT_CNT_EN
    // grant counters and clear priority
    step(8'h00, 0, 1, 0, 0, 0, 0);
    acc_q.delete();
    for (int n = 0; n < 100 && acc_q.size() < 10; n++) step(8'h08, 1, 0, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0, 0, 0);
    check("t6_cnt10", 32'(stat_cnt_o[3]), 32'd10);
    for (int n = 0; n < 6 && !m_vld; n++) step(8'h08, 0, 0, 0, 0, 0, 0);
    check("t6_offer_ready", 32'(m_vld), 32'h1);
    step(8'h08, 1, 0, 0, 0, 0, 1);
    step(8'h00, 0, 0, 0, 0, 0, 0);
    check("t6_clear_wins", 32'(stat_cnt_o[3]), 32'd0);
`endif

    // randomized traffic, config writes and occasional resets
    step(8'h00, 0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      step(8'($urandom), ($urandom % 4) != 0, ($urandom % 128) == 0,
           ($urandom % 16) == 0, int'($urandom % 8), int'($urandom % 6),
           ($urandom % 64) == 0);
    end
    step(8'h00, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
